dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Sequences the shared word-addressed data memory (Address/WriteData/MemWrite/MemRead/ReadData) between two requesters.
- Requester 0 is the pipeline MEM stage; requester 1 is the auxiliary port (program/data loader, debug).
- Issues one access at a time with a fixed-latency memory model.
- Round-robin arbitration with a req/gnt/done handshake; returns read data to the winner.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles the MemRead/MemWrite strobes are held before ReadData is sampled; legal range 1..4.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- R0_Req  in  1  requester 0 access request; level, held until R0_Done.
- R0_Write  in  1  1 = write, 0 = read; stable while R0_Req is high.
- R0_Addr  in  ADDR_W  byte address; stable while R0_Req is high.
- R0_WData  in  DATA_W  write data; stable while R0_Req is high.
- R0_Gnt  out  1  one-cycle pulse: request accepted.
- R0_Done  out  1  one-cycle pulse: access complete.
- R0_RData  out  DATA_W  read result; valid when R0_Done is high.
- R1_Req, R1_Write, R1_Addr, R1_WData, R1_Gnt, R1_Done, R1_RData: same as R0_*, for requester 1.
- Mem_Address  out  ADDR_W  to memory Address.
- Mem_WriteData  out  DATA_W  to memory WriteData.
- Mem_MemWrite  out  1  to memory MemWrite.
- Mem_MemRead  out  1  to memory MemRead.
- Mem_ReadData  in  DATA_W  from memory ReadData.
- Busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (Rst_n low, asynchronous): state IDLE; priority pointer = R0; all outputs 0, including RData registers and Mem_* buses.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No Req: remain in IDLE.
  - One Req high: grant it.
  - Both Req high: grant the requester the pointer names.
  - On a grant: latch Write/Addr/WData and the winner ID; next edge -> ACCESS; Rn_Gnt high for the first ACCESS cycle only; pointer moves to the other requester.
- ACCESS:
  - Lasts exactly MEM_LAT cycles (down-counter loaded with MEM_LAT).
  - Mem_Address/Mem_WriteData driven from the latched values; Mem_MemWrite = latched Write; Mem_MemRead = ~latched Write. Both strobes are registered outputs.
  - On the last ACCESS cycle, for reads, Mem_ReadData is captured into the winner's RData; next edge -> DONE.
- DONE:
  - Strobes 0; winner's Done high for exactly one cycle; next edge -> IDLE.
  - Req is ignored while in DONE.
  - A Req still high in the following IDLE cycle is a new request.
- Latency: Req first sampled in IDLE at cycle 0 -> Gnt at cycle 1 -> Done at cycle MEM_LAT+1. Back-to-back service period is MEM_LAT+2 cycles.
- RData is updated only on reads; writes leave it unchanged. The loser's RData is never touched.
- In IDLE and DONE, Mem_Address/Mem_WriteData hold their last driven values; strobes are 0. MemRead and MemWrite are never high together.
- Req dropped mid-access: the access still completes and Done still pulses.
- Fairness: with both requesters continuously requesting, grants alternate R0, R1, R0, …
- Reset asserted mid-access: immediate return to the reset state; strobes drop asynchronously. A write whose edge has already passed stays in memory; no Done is issued.
- A Write/Addr change while Req is high after Gnt has no effect; the values are latched.

Decomposition:
- Package dmem_arb_pkg: state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2), requester IDs (REQ_PIPE=0, REQ_AUX=1), and default width constants.
- One sub-module rr_arbiter2: combinational 2-way pick plus a registered pointer that updates on a grant enable.

Test Plan:
- Single read, MEM_LAT=1:
  - Stimulus: preload mem[0]=4; R0 read Addr=0.
  - Required: R0_Gnt at cycle 1; Mem_MemRead high at cycle 1 only; R0_Done at cycle 2 with R0_RData=4; R1 outputs stay 0.
- Write then readback via R1:
  - Stimulus: R1 write Addr=4, WData=7; then R1 read Addr=4.
  - Required: Mem_MemWrite one cycle with Mem_Address=4 and Mem_WriteData=7; the read returns R1_RData=7.
- Simultaneous requests after reset:
  - Stimulus: R0 and R1 both read in the same cycle.
  - Required: R0 granted first, R1 granted in the IDLE cycle after R0_Done; sustained requests give the grant order 0,1,0,1.
- MEM_LAT=3:
  - Stimulus: R0 read of mem[8]=0x12345678.
  - Required: strobe high for 3 cycles; R0_Done at cycle 4 with RData=0x12345678; Busy high for cycles 1–4.
- Reset mid-ACCESS:
  - Stimulus: assert Rst_n=0 during cycle 2 of a MEM_LAT=3 read.
  - Required: strobes, Gnt, Done and Busy go 0 immediately; no Done pulse; after release, the next simultaneous request grants R0.
- Req dropped after Gnt:
  - Stimulus: R1 deasserts Req the cycle after Gnt.
  - Required: R1_Done still pulses at cycle MEM_LAT+1; the FSM returns to IDLE.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pkg
// Brief    : Shared encodings and default widths for the data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    localparam int c_ADDR_W = 32;
    localparam int c_DATA_W = 32;
    localparam int c_LAT_W  = 3;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;

    localparam logic c_REQ_PIPE = 1'b0;
    localparam logic c_REQ_AUX  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Brief    : Two-way round-robin pick; pointer flips away from each winner.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic Clk,
    input  logic Rst_n,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_en,
    output logic o_valid,
    output logic o_winner
);

    logic r_ptr;

    assign o_valid  = i_req0 | i_req1;
    // The pointer only matters on a tie; otherwise the lone requester wins.
    assign o_winner = (i_req0 && i_req1) ? r_ptr : i_req1;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_ptr <= c_REQ_PIPE;
        end else if (i_en) begin
            r_ptr <= ~o_winner;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Sequences a fixed-latency data memory between the pipeline MEM
//            stage and an auxiliary port with a req/gnt/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W  = c_ADDR_W,
    parameter int DATA_W  = c_DATA_W,
    parameter int MEM_LAT = 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              R0_Req,
    input  logic              R0_Write,
    input  logic [ADDR_W-1:0] R0_Addr,
    input  logic [DATA_W-1:0] R0_WData,
    output logic              R0_Gnt,
    output logic              R0_Done,
    output logic [DATA_W-1:0] R0_RData,
    input  logic              R1_Req,
    input  logic              R1_Write,
    input  logic [ADDR_W-1:0] R1_Addr,
    input  logic [DATA_W-1:0] R1_WData,
    output logic              R1_Gnt,
    output logic              R1_Done,
    output logic [DATA_W-1:0] R1_RData,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic [DATA_W-1:0] Mem_WriteData,
    output logic              Mem_MemWrite,
    output logic              Mem_MemRead,
    input  logic [DATA_W-1:0] Mem_ReadData,
    output logic              Busy
);

    localparam logic [c_LAT_W-1:0] c_LAT = c_LAT_W'(MEM_LAT);

    logic [1:0]         r_state;
    logic [c_LAT_W-1:0] r_cnt;
    logic               r_winner;
    logic               r_write;
    logic [ADDR_W-1:0]  r_memAddr;
    logic [DATA_W-1:0]  r_memWData;
    logic               r_memWrite;
    logic               r_memRead;
    logic               r_gnt0;
    logic               r_gnt1;
    logic               r_done0;
    logic               r_done1;
    logic [DATA_W-1:0]  r_rdata0;
    logic [DATA_W-1:0]  r_rdata1;

    logic               w_valid;
    logic               w_winner;
    logic               w_grant;
    logic               w_reqWrite;
    logic [ADDR_W-1:0]  w_reqAddr;
    logic [DATA_W-1:0]  w_reqWData;

    assign w_grant    = (r_state == c_ST_IDLE) && w_valid;
    assign w_reqWrite = w_winner ? R1_Write : R0_Write;
    assign w_reqAddr  = w_winner ? R1_Addr  : R0_Addr;
    assign w_reqWData = w_winner ? R1_WData : R0_WData;

    rr_arbiter2 u_rr (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .i_req0   (R0_Req),
        .i_req1   (R1_Req),
        .i_en     (w_grant),
        .o_valid  (w_valid),
        .o_winner (w_winner)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_winner   <= c_REQ_PIPE;
            r_write    <= 1'b0;
            r_memAddr  <= '0;
            r_memWData <= '0;
            r_memWrite <= 1'b0;
            r_memRead  <= 1'b0;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_valid) begin
                        r_state    <= c_ST_ACCESS;
                        r_cnt      <= c_LAT;
                        r_winner   <= w_winner;
                        r_write    <= w_reqWrite;
                        r_memAddr  <= w_reqAddr;
                        r_memWData <= w_reqWData;
                        r_memWrite <= w_reqWrite;
                        r_memRead  <= ~w_reqWrite;
                        r_gnt0     <= (w_winner == c_REQ_PIPE);
                        r_gnt1     <= (w_winner == c_REQ_AUX);
                    end
                end
                c_ST_ACCESS: begin
                    if (r_cnt == c_LAT_W'(1)) begin
                        r_state    <= c_ST_DONE;
                        r_memWrite <= 1'b0;
                        r_memRead  <= 1'b0;
                        r_done0    <= (r_winner == c_REQ_PIPE);
                        r_done1    <= (r_winner == c_REQ_AUX);
                        // Only the winner's read result register is touched.
                        if (!r_write) begin
                            if (r_winner == c_REQ_AUX) begin
                                r_rdata1 <= Mem_ReadData;
                            end else begin
                                r_rdata0 <= Mem_ReadData;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - c_LAT_W'(1);
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign R0_Gnt        = r_gnt0;
    assign R1_Gnt        = r_gnt1;
    assign R0_Done       = r_done0;
    assign R1_Done       = r_done1;
    assign R0_RData      = r_rdata0;
    assign R1_RData      = r_rdata1;
    assign Mem_Address   = r_memAddr;
    assign Mem_WriteData = r_memWData;
    assign Mem_MemWrite  = r_memWrite;
    assign Mem_MemRead   = r_memRead;
    assign Busy          = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire
